// File: rtl/approx_add_pipe.sv
// ---------------------------------------------------------------------------
// approx_add_pipe
//
// Pipelined N-bit unsigned adder. Each beat can ask for either the exact sum
// or an approximate one. The approximate sum ORs the low K bits together and
// feeds the upper N-K bits through an exact carry chain. That chain gets its
// carry-in predicted from bit K-1 alone.
//
// The block computes both sums for every beat, so it can flag an approximate
// result that differs from the exact one.
//
// The ripple chain is cut into STAGES segments of ceil(N/STAGES) bits, and
// the last segment takes whatever bits remain. One register stage sits after
// each segment, so latency is STAGES cycles from accept to output transfer.
// The handshake is valid/ready at both ends, bubbles collapse, and throughput
// is one beat per cycle.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    operand beat valid
//   in_ready   out  1    block accepts a beat this cycle
//   in_a       in   N    operand A
//   in_b       in   N    operand B
//   in_mode    in   1    0 = exact sum, 1 = approximate sum
//   out_valid  out  1    result beat valid
//   out_ready  in   1    consumer takes the result this cycle
//   out_sum    out  N+1  result including carry-out
//   out_err    out  1    approximate result differs from exact sum
// ---------------------------------------------------------------------------
module approx_add_pipe #(
    parameter int N      = 16,
    parameter int K      = 12,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_sum,
    output logic         out_err
);

    localparam int SEG_W = (N + STAGES - 1) / STAGES;

    // Everything one beat carries between stages. Operand bits are kept in
    // full so that later segments can read their slice. The sum fields fill
    // in segment by segment. c_ex and c_ap are the carries leaving the most
    // recently finished segment.
    typedef struct packed {
        logic         mode;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum_ex;
        logic [N-1:0] sum_ap;
        logic         c_ex;
        logic         c_ap;
    } beat_t;

    beat_t              beat_q   [STAGES];
    beat_t              beat_d   [STAGES];
    beat_t              stage_in [STAGES];
    logic [STAGES-1:0]  up_valid;
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  ready;

    beat_t              out_beat;
    logic [N:0]         exact_sum;
    logic [N:0]         approx_sum;

    // Segment bounds are clamped to N. This keeps segments empty when STAGES
    // is larger than needed for a small N, for example N=2 with STAGES=4.
    function automatic int seg_lo(input int s);
        int lo;
        lo = s * SEG_W;
        return (lo > N) ? N : lo;
    endfunction

    function automatic int seg_hi(input int s);
        int hi;
        hi = (s == STAGES - 1) ? N : (s + 1) * SEG_W;
        return (hi > N) ? N : hi;
    endfunction

    // Ripple both adders across bits [lo, hi).
    // Below K, the approximate adder emits a|b and propagates no carry,
    // except at bit K-1, where a&b becomes the predicted carry into the
    // exact upper part.
    function automatic beat_t seg_add(input beat_t b_in, input int lo, input int hi);
        beat_t r;
        logic  cx;
        logic  ca;
        logic  ai;
        logic  bi;
        r  = b_in;
        cx = b_in.c_ex;
        ca = b_in.c_ap;
        for (int i = 0; i < N; i++) begin
            ai = b_in.a[i];
            bi = b_in.b[i];
            if (i >= lo && i < hi) begin
                r.sum_ex[i] = ai ^ bi ^ cx;
                cx          = (ai & bi) | (cx & (ai ^ bi));
                if (i < K) begin
                    r.sum_ap[i] = ai | bi;
                    ca          = (i == K - 1) ? (ai & bi) : 1'b0;
                end else begin
                    r.sum_ap[i] = ai ^ bi ^ ca;
                    ca          = (ai & bi) | (ca & (ai ^ bi));
                end
            end
        end
        r.c_ex = cx;
        r.c_ap = ca;
        return r;
    endfunction

    // Stage s can load when it is empty, or when everything downstream of it
    // drains this cycle. The recursive ready chain is unrolled here into
    // "out_ready or some stage from s onward is empty".
    always_comb begin
        logic all_full;
        all_full = 1'b0;
        ready    = '0;
        for (int s = 0; s < STAGES; s++) begin
            all_full = 1'b1;
            for (int t = s; t < STAGES; t++) begin
                all_full = all_full & valid_q[t];
            end
            ready[s] = out_ready | ~all_full;
        end
    end

    assign in_ready = ready[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign stage_in[s] = '{mode:   in_mode,
                                   a:      in_a,
                                   b:      in_b,
                                   sum_ex: '0,
                                   sum_ap: '0,
                                   c_ex:   1'b0,
                                   c_ap:   1'b0};
            assign up_valid[s] = in_valid;
        end else begin : g_next
            assign stage_in[s] = beat_q[s-1];
            assign up_valid[s] = valid_q[s-1];
        end
        assign beat_d[s] = seg_add(stage_in[s], seg_lo(s), seg_hi(s));
    end

    // Data registers load only on a real transfer. A stalled stage, or one
    // that has just emptied, therefore keeps its contents, and the outputs
    // stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                beat_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ready[s]) begin
                    valid_q[s] <= up_valid[s];
                    if (up_valid[s]) begin
                        beat_q[s] <= beat_d[s];
                    end
                end
            end
        end
    end

    assign out_beat   = beat_q[STAGES-1];
    assign exact_sum  = {out_beat.c_ex, out_beat.sum_ex};
    assign approx_sum = {out_beat.c_ap, out_beat.sum_ap};

    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = out_beat.mode ? approx_sum : exact_sum;
    assign out_err   = out_beat.mode & (approx_sum != exact_sum);

endmodule

// File: tb/tb_approx_add_pipe.sv
module tb_approx_add_pipe;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed instance: N=16, K=12, STAGES=2
    logic        d_valid, d_ready, d_mode, d_ovalid, d_oready, d_err;
    logic [15:0] d_a, d_b;
    logic [16:0] d_sum;

    approx_add_pipe #(.N(16), .K(12), .STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_valid), .in_ready(d_ready),
        .in_a(d_a), .in_b(d_b), .in_mode(d_mode),
        .out_valid(d_ovalid), .out_ready(d_oready),
        .out_sum(d_sum), .out_err(d_err));

    // Random-scoreboard instances sharing one driver
    logic        r_valid, r_mode, r_oready;
    logic [31:0] r_a, r_b;
    logic        rdy1, rdy2, rdy3, ov1, ov2, ov3, e1, e2, e3;
    logic [16:0] s1, s2;
    logic [32:0] s3;
    logic        all_rdy, r_iv;

    assign all_rdy = rdy1 & rdy2 & rdy3;
    assign r_iv    = r_valid & all_rdy;

    approx_add_pipe #(.N(16), .K(0), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_iv), .in_ready(rdy1),
        .in_a(r_a[15:0]), .in_b(r_b[15:0]), .in_mode(r_mode),
        .out_valid(ov1), .out_ready(r_oready),
        .out_sum(s1), .out_err(e1));

    approx_add_pipe #(.N(16), .K(4), .STAGES(3)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_iv), .in_ready(rdy2),
        .in_a(r_a[15:0]), .in_b(r_b[15:0]), .in_mode(r_mode),
        .out_valid(ov2), .out_ready(r_oready),
        .out_sum(s2), .out_err(e2));

    approx_add_pipe #(.N(32), .K(20), .STAGES(4)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_iv), .in_ready(rdy3),
        .in_a(r_a), .in_b(r_b), .in_mode(r_mode),
        .out_valid(ov3), .out_ready(r_oready),
        .out_sum(s3), .out_err(e3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // err in bit 40, sum in bits [32:0]
    function automatic logic [63:0] pk(input logic e, input logic [32:0] s);
        return {23'd0, e, 7'd0, s};
    endfunction

    // Reference built straight from the arithmetic definition
    function automatic logic [63:0] ref_res(input int n, input int k, input logic m,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] a, b, ex, ap, lo, hi, cin;
        logic e;
        a  = a_in & ((64'd1 << n) - 64'd1);
        b  = b_in & ((64'd1 << n) - 64'd1);
        ex = a + b;
        if (k == 0) begin
            lo  = '0;
            cin = '0;
        end else begin
            lo  = (a | b) & ((64'd1 << k) - 64'd1);
            cin = (a >> (k - 1)) & (b >> (k - 1)) & 64'd1;
        end
        hi = (a >> k) + (b >> k) + cin;
        ap = (hi << k) | lo;
        e  = m && (ap != ex);
        return pk(e, m ? ap[32:0] : ex[32:0]);
    endfunction

    // Operands must not move while a beat waits for in_ready
    logic        hold_q = 1'b0;
    logic [63:0] hold_v = '0;
    always @(negedge clk) begin
        if (hold_q) chk("input stable while waiting", {31'd0, d_mode, d_a, d_b}, hold_v);
        hold_q = d_valid && !d_ready && rst_n;
        hold_v = {31'd0, d_mode, d_a, d_b};
    end

    task automatic send_one(input string tag, input logic m, input logic [15:0] a,
                            input logic [15:0] b, input logic [16:0] es, input logic ee);
        int lat;
        bit done;
        d_mode = m; d_a = a; d_b = b; d_valid = 1'b1; d_oready = 1'b1;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(d_ready), 64'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        lat = 0; done = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (d_ovalid) done = 1;
        end
        chk({tag, " latency"}, 64'(lat), 64'd2);
        chk({tag, " sum/err"}, pk(d_err, 33'(d_sum)), pk(ee, 33'(es)));
        @(posedge clk); #1;
    endtask

    logic [15:0] sa [8] = '{16'h0001, 16'h0001, 16'h0FFF, 16'h0FFF, 16'h8000, 16'hABCD, 16'hABCD, 16'hFFFF};
    logic [15:0] sb [8] = '{16'h0002, 16'h0002, 16'h0FFF, 16'h0FFF, 16'h8000, 16'h1111, 16'h1111, 16'h0000};
    logic        sm [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [16:0] ss [8] = '{17'h00003, 17'h00003, 17'h01FFF, 17'h01FFE, 17'h10000, 17'h0BCDE, 17'h0BBDD, 17'h0FFFF};
    logic        se [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    localparam int NR = 10000;

    int          bi, got, acc_stall, first_c, last_c, idx, seen, r_beats;
    bit          acc, have_hold;
    logic [63:0] held;
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];
    logic [63:0] q3 [$];
    logic [63:0] exp_v;

    initial begin
        rst_n = 1'b0;
        d_valid = 1'b0; d_mode = 1'b0; d_a = '0; d_b = '0; d_oready = 1'b1;
        r_valid = 1'b0; r_mode = 1'b0; r_a = '0; r_b = '0; r_oready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(d_ovalid), 64'd0);
        chk("reset out_sum/err", pk(d_err, 33'(d_sum)), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready after reset", 64'(d_ready), 64'd1);
        @(posedge clk); #1;

        // Directed single beats
        send_one("exact carry-out", 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0);
        send_one("approx 1234+4321", 1'b1, 16'h1234, 16'h4321, 17'h05335, 1'b1);
        send_one("approx predicted carry", 1'b1, 16'h0800, 16'h0800, 17'h01800, 1'b1);
        send_one("approx upper only", 1'b1, 16'h1000, 16'h2000, 17'h03000, 1'b0);
        send_one("approx upper carry-out", 1'b1, 16'hF000, 16'h1000, 17'h10000, 1'b0);
        send_one("exact all ones", 1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0);
        send_one("approx all ones", 1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFF, 1'b1);
        send_one("exact mode no err", 1'b0, 16'h1234, 16'h4321, 17'h05555, 1'b0);
        send_one("approx missed carry", 1'b1, 16'h0FFF, 16'h0001, 17'h00FFF, 1'b1);

        // Streaming with a 5-cycle output stall at the start
        bi = 0; got = 0; acc_stall = 0; first_c = -1; last_c = -1; have_hold = 0; held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            d_valid  = (bi < 8);
            idx      = (bi < 8) ? bi : 7;
            d_mode   = sm[idx]; d_a = sa[idx]; d_b = sb[idx];
            d_oready = (c >= 5);
            @(negedge clk);
            acc = d_valid && d_ready;
            if (acc && c < 5) acc_stall++;
            if (c == 4) begin
                chk("stream in_ready low in stall", 64'(d_ready), 64'd0);
                chk("stream beats taken before stall", 64'(acc_stall), 64'd2);
            end
            if (d_ovalid && !d_oready) begin
                if (have_hold)
                    chk("stream stall hold", pk(d_err, 33'(d_sum)) | (64'(d_ovalid) << 48), held);
                held = pk(d_err, 33'(d_sum)) | (64'(d_ovalid) << 48);
                have_hold = 1;
            end
            if (d_ovalid && d_oready) begin
                chk($sformatf("stream beat %0d", got), pk(d_err, 33'(d_sum)), pk(se[got], 33'(ss[got])));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            @(posedge clk); #1;
            if (acc) bi++;
        end
        d_valid = 1'b0;
        chk("stream beats out", 64'(got), 64'd8);
        chk("stream no gaps", 64'(last_c - first_c), 64'd7);

        // Reset with two beats in flight
        d_oready = 1'b0; d_mode = 1'b0; d_a = 16'h0003; d_b = 16'h0004; d_valid = 1'b1;
        @(posedge clk); #1;
        d_a = 16'h0005; d_b = 16'h0006;
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk);
        chk("in flight before reset", 64'(d_ovalid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; d_oready = 1'b1;
        @(negedge clk);
        chk("mid reset out_valid", 64'(d_ovalid), 64'd0);
        chk("mid reset out_sum/err", pk(d_err, 33'(d_sum)), 64'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ovalid) seen++;
        end
        chk("no stale results", 64'(seen), 64'd0);
        @(posedge clk); #1;
        send_one("after reset", 1'b0, 16'h0100, 16'h0200, 17'h00300, 1'b0);

        // Random scoreboard on the alternate configurations
        r_beats = 0;
        for (int c = 0; c < 60000 && (r_beats < NR || q1.size() != 0 || q2.size() != 0 || q3.size() != 0); c++) begin
            if (!r_valid && r_beats < NR && $urandom_range(0, 7) != 0) begin
                r_valid = 1'b1;
                r_mode  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0:       r_a = '1;
                    1:       r_a = '0;
                    default: r_a = $urandom();
                endcase
                case ($urandom_range(0, 7))
                    0:       r_b = '1;
                    1:       r_b = '0;
                    default: r_b = $urandom();
                endcase
            end
            r_oready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = r_valid && all_rdy;
            if (acc) begin
                q1.push_back(ref_res(16, 0,  r_mode, 64'(r_a[15:0]), 64'(r_b[15:0])));
                q2.push_back(ref_res(16, 4,  r_mode, 64'(r_a[15:0]), 64'(r_b[15:0])));
                q3.push_back(ref_res(32, 20, r_mode, 64'(r_a), 64'(r_b)));
            end
            if (ov1 && r_oready) begin
                chk("K0 out_err", 64'(e1), 64'd0);
                if (q1.size() == 0) chk("K0 spurious output", 64'(q1.size()), 64'd1);
                else begin exp_v = q1.pop_front(); chk("K0 S1 result", pk(e1, 33'(s1)), exp_v); end
            end
            if (ov2 && r_oready) begin
                if (q2.size() == 0) chk("K4 spurious output", 64'(q2.size()), 64'd1);
                else begin exp_v = q2.pop_front(); chk("K4 S3 result", pk(e2, 33'(s2)), exp_v); end
            end
            if (ov3 && r_oready) begin
                if (q3.size() == 0) chk("N32 spurious output", 64'(q3.size()), 64'd1);
                else begin exp_v = q3.pop_front(); chk("N32 K20 S4 result", pk(e3, s3), exp_v); end
            end
            @(posedge clk); #1;
            if (acc) begin
                r_beats++;
                r_valid = 1'b0;
            end
        end
        r_valid = 1'b0;
        chk("random beats sent", 64'(r_beats), 64'(NR));
        chk("K0 results drained", 64'(q1.size()), 64'd0);
        chk("K4 results drained", 64'(q2.size()), 64'd0);
        chk("N32 results drained", 64'(q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
